// File: rtl/rv32_bus_pkg.sv
// Shared widths, defaults and FSM encoding for the picorv32 native-bus interconnect.
// Imported by the address decoder and the interconnect top.
package rv32_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/rv32_addr_decode.sv
// Combinational base/mask window decoder; when windows overlap the lowest slot index wins.
// Slot i of the packed base/mask vectors occupies bits [32i+31:32i].
module rv32_addr_decode
  import rv32_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_BASES =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS = {4{32'hF000_0000}},
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [SEL_W-1:0]  sel_idx
);

  logic [NUM_SLAVES-1:0] match_s;

  // Per-window compare, then a downward scan so lower indices overwrite higher ones.
  always_comb begin
    match_s = '0;
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match_s[i] = ((addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) ==
                    (ADDR_BASES[i*ADDR_W +: ADDR_W] & ADDR_MASKS[i*ADDR_W +: ADDR_W]));
    end
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      sel_idx = match_s[i] ? i[SEL_W-1:0] : sel_idx;
      hit     = hit | match_s[i];
    end
  end

endmodule

// File: rtl/rv32_interconnect.sv
// Routes one picorv32 native bus to NUM_SLAVES address windows with a registered decode,
// per-transaction timeout, an error responder and sticky debug error registers.
module rv32_interconnect
  import rv32_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_BASES =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] ADDR_MASKS = {4{32'hF000_0000}},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = DEFAULT_ERR_RDATA,
  parameter int CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rv32_valid,
  output logic                         rv32_ready,
  input  logic [ADDR_W-1:0]            rv32_addr,
  input  logic [STRB_W-1:0]            rv32_wstrb,
  output logic [DATA_W-1:0]            rv32_rdata,
  output logic [NUM_SLAVES-1:0]        s_valid,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic                         err_pulse,
  output logic [ADDR_W-1:0]            err_addr,
  output logic                         err_write,
  output logic [CNT_WIDTH-1:0]         err_count
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_t               state_r, state_s;
  logic [SEL_W-1:0]     sel_r;
  logic [31:0]          timer_r;
  logic [ADDR_W-1:0]    err_addr_r;
  logic                 err_write_r;
  logic [CNT_WIDTH-1:0] err_count_r;

  logic                 dec_hit_s;
  logic [SEL_W-1:0]     dec_sel_s;
  logic                 sel_ready_s;
  logic [DATA_W-1:0]    sel_rdata_s;
  logic                 timeout_s;

  rv32_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_BASES (ADDR_BASES),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_decode (
    .addr    (rv32_addr),
    .hit     (dec_hit_s),
    .sel_idx (dec_sel_s)
  );

  // Response mux for the latched slave.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_ready_s = (sel_r == i[SEL_W-1:0]) ? s_ready[i] : sel_ready_s;
      sel_rdata_s = (sel_r == i[SEL_W-1:0]) ? s_rdata[i*DATA_W +: DATA_W] : sel_rdata_s;
    end
  end

  assign timeout_s = (TIMEOUT_CYCLES != 32'd0) && (timer_r == TIMER_LAST);

  // Next-state logic; a dropped rv32_valid mid-transfer abandons it silently.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rv32_valid) begin
          state_s = dec_hit_s ? ST_ACTIVE : ST_ERROR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!rv32_valid) begin
          state_s = ST_IDLE;
        end else if (sel_ready_s) begin
          state_s = ST_DONE;
        end else if (timeout_s) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_ACTIVE;
        end
      end
      ST_ERROR: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Bus-facing outputs decoded from the current state.
  always_comb begin
    s_valid    = '0;
    rv32_ready = 1'b0;
    rv32_rdata = '0;
    err_pulse  = 1'b0;
    case (state_r)
      ST_ACTIVE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          s_valid[i] = (sel_r == i[SEL_W-1:0]);
        end
        rv32_ready = rv32_valid & sel_ready_s;
        rv32_rdata = sel_rdata_s;
      end
      ST_ERROR: begin
        rv32_ready = 1'b1;
        rv32_rdata = ERR_RDATA;
        err_pulse  = 1'b1;
      end
      default: begin
        rv32_ready = 1'b0;
      end
    endcase
  end

  // State, slave select, timer and error capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= '0;
      timer_r     <= 32'd0;
      err_addr_r  <= '0;
      err_write_r <= 1'b0;
      err_count_r <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && rv32_valid && dec_hit_s) begin
        sel_r <= dec_sel_s;
      end
      timer_r <= ((state_r == ST_ACTIVE) && (state_s == ST_ACTIVE)) ? timer_r + 32'd1 : 32'd0;
      if (state_s == ST_ERROR) begin
        err_addr_r  <= rv32_addr;
        err_write_r <= |rv32_wstrb;
        err_count_r <= sat_inc(err_count_r);
      end
    end
  end

  assign err_addr  = err_addr_r;
  assign err_write = err_write_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_rv32_interconnect.sv
// Directed self-checking bench: default map, overlapping-window map and a short-timeout map.
module tb_rv32_interconnect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   errors = 0;
  int   checks = 0;

  // Default-map instance
  logic         m_valid, m_ready, m_err_pulse, m_err_write;
  logic [31:0]  m_addr, m_rdata, m_err_addr;
  logic [3:0]   m_wstrb, m_s_valid, m_s_ready;
  logic [127:0] m_s_rdata;
  logic [7:0]   m_err_count;

  // Overlapping-window instance
  logic         o_valid, o_ready, o_err_pulse, o_err_write;
  logic [31:0]  o_addr, o_rdata, o_err_addr;
  logic [3:0]   o_wstrb, o_s_valid, o_s_ready;
  logic [127:0] o_s_rdata;
  logic [7:0]   o_err_count;

  // Short-timeout instance
  logic         t_valid, t_ready, t_err_pulse, t_err_write;
  logic [31:0]  t_addr, t_rdata, t_err_addr;
  logic [3:0]   t_wstrb, t_s_valid, t_s_ready;
  logic [127:0] t_s_rdata;
  logic [7:0]   t_err_count;

  rv32_interconnect dut (
    .clk(clk), .reset(reset), .rv32_valid(m_valid), .rv32_ready(m_ready),
    .rv32_addr(m_addr), .rv32_wstrb(m_wstrb), .rv32_rdata(m_rdata),
    .s_valid(m_s_valid), .s_ready(m_s_ready), .s_rdata(m_s_rdata),
    .err_pulse(m_err_pulse), .err_addr(m_err_addr), .err_write(m_err_write),
    .err_count(m_err_count)
  );

  rv32_interconnect #(
    .ADDR_MASKS({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h0000_0000})
  ) dut_ov (
    .clk(clk), .reset(reset), .rv32_valid(o_valid), .rv32_ready(o_ready),
    .rv32_addr(o_addr), .rv32_wstrb(o_wstrb), .rv32_rdata(o_rdata),
    .s_valid(o_s_valid), .s_ready(o_s_ready), .s_rdata(o_s_rdata),
    .err_pulse(o_err_pulse), .err_addr(o_err_addr), .err_write(o_err_write),
    .err_count(o_err_count)
  );

  rv32_interconnect #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset), .rv32_valid(t_valid), .rv32_ready(t_ready),
    .rv32_addr(t_addr), .rv32_wstrb(t_wstrb), .rv32_rdata(t_rdata),
    .s_valid(t_s_valid), .s_ready(t_s_ready), .s_rdata(t_s_rdata),
    .err_pulse(t_err_pulse), .err_addr(t_err_addr), .err_write(t_err_write),
    .err_count(t_err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0000) begin errors++; $display("FAIL rst_svalid got=%b exp=0000", m_s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", m_ready); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", m_rdata); end
    checks++; if (m_err_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got=%b exp=0", m_err_pulse); end
    checks++; if (m_err_addr !== 32'h0) begin errors++; $display("FAIL rst_err_addr got=%h exp=0", m_err_addr); end
    checks++; if (m_err_write !== 1'b0) begin errors++; $display("FAIL rst_err_write got=%b exp=0", m_err_write); end
    checks++; if (m_err_count !== 8'h00) begin errors++; $display("FAIL rst_err_count got=%h exp=00", m_err_count); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_read();
    m_valid = 1'b1; m_addr = 32'h1000_0010; m_wstrb = 4'h0;
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0000) begin errors++; $display("FAIL read_decode_cycle got=%b exp=0000", m_s_valid); end
    step();
    m_s_ready = 4'b1101;
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0010) begin errors++; $display("FAIL read_svalid1 got=%b exp=0010", m_s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL read_unsel_ready got=%b exp=0", m_ready); end
    step();
    m_s_ready = 4'b0010;
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0010) begin errors++; $display("FAIL read_svalid2 got=%b exp=0010", m_s_valid); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL read_ready got=%b exp=1", m_ready); end
    checks++; if (m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL read_rdata got=%h exp=12345678", m_rdata); end
    step();
    m_s_ready = 4'b0000; m_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0000) begin errors++; $display("FAIL read_done_svalid got=%b exp=0000", m_s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL read_done_ready got=%b exp=0", m_ready); end
    checks++; if (m_err_count !== 8'h00) begin errors++; $display("FAIL read_err_count got=%h exp=00", m_err_count); end
    step();
  endtask

  task automatic test_unmapped();
    m_valid = 1'b1; m_addr = 32'h5000_0000; m_wstrb = 4'h0;
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL unm_idle_ready got=%b exp=0", m_ready); end
    step();
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0000) begin errors++; $display("FAIL unm_svalid got=%b exp=0000", m_s_valid); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL unm_ready got=%b exp=1", m_ready); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unm_rdata got=%h exp=deadbeef", m_rdata); end
    checks++; if (m_err_pulse !== 1'b1) begin errors++; $display("FAIL unm_pulse got=%b exp=1", m_err_pulse); end
    checks++; if (m_err_addr !== 32'h5000_0000) begin errors++; $display("FAIL unm_err_addr got=%h exp=50000000", m_err_addr); end
    checks++; if (m_err_write !== 1'b0) begin errors++; $display("FAIL unm_err_write got=%b exp=0", m_err_write); end
    checks++; if (m_err_count !== 8'h01) begin errors++; $display("FAIL unm_err_count got=%h exp=01", m_err_count); end
    step();
    m_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL unm_done_ready got=%b exp=0", m_ready); end
    checks++; if (m_err_pulse !== 1'b0) begin errors++; $display("FAIL unm_done_pulse got=%b exp=0", m_err_pulse); end
    checks++; if (m_err_addr !== 32'h5000_0000) begin errors++; $display("FAIL unm_hold_addr got=%h exp=50000000", m_err_addr); end
    step();
  endtask

  task automatic test_saturation();
    logic [7:0] exp_cnt;
    exp_cnt = 8'h01;
    for (int n = 0; n < 255; n++) begin
      m_valid = 1'b1; m_addr = 32'h8000_0000 | n; m_wstrb = 4'h0;
      step();
      m_valid = 1'b0;
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'h01;
      @(negedge clk);
      checks++; if (m_err_count !== exp_cnt) begin errors++; $display("FAIL sat_count[%0d] got=%h exp=%h", n, m_err_count, exp_cnt); end
      checks++; if (m_err_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse[%0d] got=%b exp=1", n, m_err_pulse); end
      step();
      step();
    end
    checks++; if (m_err_count !== 8'hFF) begin errors++; $display("FAIL sat_final got=%h exp=ff", m_err_count); end
    checks++; if (m_err_addr !== 32'h8000_00FE) begin errors++; $display("FAIL sat_addr got=%h exp=800000fe", m_err_addr); end
  endtask

  task automatic test_write_error();
    m_valid = 1'b1; m_addr = 32'hC000_0004; m_wstrb = 4'h3;
    step();
    @(negedge clk);
    checks++; if (m_err_write !== 1'b1) begin errors++; $display("FAIL werr_write got=%b exp=1", m_err_write); end
    checks++; if (m_err_addr !== 32'hC000_0004) begin errors++; $display("FAIL werr_addr got=%h exp=c0000004", m_err_addr); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL werr_ready got=%b exp=1", m_ready); end
    checks++; if (m_err_count !== 8'hFF) begin errors++; $display("FAIL werr_count got=%h exp=ff", m_err_count); end
    step();
    m_valid = 1'b0; m_wstrb = 4'h0;
    step();
  endtask

  task automatic test_abort();
    m_valid = 1'b1; m_addr = 32'h3000_0000; m_wstrb = 4'h0;
    step();
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b1000) begin errors++; $display("FAIL abort_svalid got=%b exp=1000", m_s_valid); end
    step();
    m_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", m_ready); end
    step();
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0000) begin errors++; $display("FAIL abort_idle_svalid got=%b exp=0000", m_s_valid); end
    checks++; if (m_err_pulse !== 1'b0) begin errors++; $display("FAIL abort_pulse got=%b exp=0", m_err_pulse); end
    checks++; if (m_err_write !== 1'b1) begin errors++; $display("FAIL abort_err_write got=%b exp=1", m_err_write); end
    step();
  endtask

  task automatic test_overlap();
    o_valid = 1'b1; o_addr = 32'h2000_0000; o_wstrb = 4'h0;
    step();
    o_s_ready = 4'b0101;
    @(negedge clk);
    checks++; if (o_s_valid !== 4'b0001) begin errors++; $display("FAIL ovl_svalid got=%b exp=0001", o_s_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ovl_ready got=%b exp=1", o_ready); end
    checks++; if (o_rdata !== 32'h0F0F_0F0F) begin errors++; $display("FAIL ovl_rdata got=%h exp=0f0f0f0f", o_rdata); end
    step();
    o_valid = 1'b0; o_s_ready = 4'b0000;
    @(negedge clk);
    checks++; if (o_s_valid !== 4'b0000) begin errors++; $display("FAIL ovl_done_svalid got=%b exp=0000", o_s_valid); end
    step();
  endtask

  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    t_valid = 1'b1; t_addr = 32'h3000_0040; t_wstrb = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 6) t_valid = 1'b0;
      @(negedge clk);
      if (t_s_valid[3]) high_cycles++;
      if (c == 5) begin
        checks++; if (t_s_valid !== 4'b0000) begin errors++; $display("FAIL to_err_svalid got=%b exp=0000", t_s_valid); end
        checks++; if (t_ready !== 1'b1) begin errors++; $display("FAIL to_ready got=%b exp=1", t_ready); end
        checks++; if (t_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_rdata got=%h exp=deadbeef", t_rdata); end
        checks++; if (t_err_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", t_err_pulse); end
        checks++; if (t_err_write !== 1'b1) begin errors++; $display("FAIL to_err_write got=%b exp=1", t_err_write); end
        checks++; if (t_err_addr !== 32'h3000_0040) begin errors++; $display("FAIL to_err_addr got=%h exp=30000040", t_err_addr); end
        checks++; if (t_err_count !== 8'h01) begin errors++; $display("FAIL to_err_count got=%h exp=01", t_err_count); end
      end
    end
    checks++; if (high_cycles !== 4) begin errors++; $display("FAIL to_svalid_cycles got=%0d exp=4", high_cycles); end
    step();
  endtask

  task automatic test_reset_mid();
    m_valid = 1'b1; m_addr = 32'h2000_0010; m_wstrb = 4'h0; m_s_ready = 4'b0000;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0100) begin errors++; $display("FAIL rmid_svalid got=%b exp=0100", m_s_valid); end
    step();
    reset = 1'b0; m_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0000) begin errors++; $display("FAIL rmid_after_svalid got=%b exp=0000", m_s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rmid_after_ready got=%b exp=0", m_ready); end
    checks++; if (m_err_count !== 8'h00) begin errors++; $display("FAIL rmid_count got=%h exp=00", m_err_count); end
    step();
    m_valid = 1'b1; m_addr = 32'h0000_0100; m_s_ready = 4'b0001;
    step();
    @(negedge clk);
    checks++; if (m_s_valid !== 4'b0001) begin errors++; $display("FAIL rmid_s0_svalid got=%b exp=0001", m_s_valid); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rmid_s0_ready got=%b exp=1", m_ready); end
    checks++; if (m_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL rmid_s0_rdata got=%h exp=a5a50001", m_rdata); end
    step();
    m_valid = 1'b0; m_s_ready = 4'b0000;
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rmid_s0_done got=%b exp=0", m_ready); end
    step();
  endtask

  initial begin
    m_valid = 1'b0; m_addr = 32'h0; m_wstrb = 4'h0; m_s_ready = 4'h0;
    m_s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hA5A5_0001};
    o_valid = 1'b0; o_addr = 32'h0; o_wstrb = 4'h0; o_s_ready = 4'h0;
    o_s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
    t_valid = 1'b0; t_addr = 32'h0; t_wstrb = 4'h0; t_s_ready = 4'h0;
    t_s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    test_reset();
    test_read();
    test_unmapped();
    test_saturation();
    test_write_error();
    test_abort();
    test_overlap();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
